// File: rtl/parity_check_ctrl_if.sv
// Serial-in / frame-out bundle for parity_check_ctrl.
// The slave modport is the receiver; the master modport drives bits and consumes frames.
interface parity_check_ctrl_if;
  logic       sin;
  logic       svalid;
  logic       dready;
  logic [3:0] dout;
  logic       dvalid;
  logic       pec;

  modport master (
    output sin,
    output svalid,
    output dready,
    input  dout,
    input  dvalid,
    input  pec
  );

  modport slave (
    input  sin,
    input  svalid,
    input  dready,
    output dout,
    output dvalid,
    output pec
  );
endinterface

// File: rtl/parity_check_ctrl.sv
// Receives 5-bit serial frames (A,B,C,D,P), checks parity, holds the result
// until the consumer takes it, and keeps frame/error/overrun statistics.
module parity_check_ctrl #(
  parameter int ODD_PARITY = 0,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_check_ctrl_if.slave   bus,
  input  logic                 clr_i,
  output logic                 toerr_o,
  output logic                 ovr_o,
  output logic                 busy_o,
  output logic [7:0]           errcnt_o,
  output logic [7:0]           frmcnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX,
    S_HOLD
  } state_e;

  localparam logic       ODD_BIT    = (ODD_PARITY != 0);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] IDX_P      = 3'd4;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] shreg_q, shreg_d;
  logic [3:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;
  logic       pec_q, pec_d;
  logic       toerr_q, toerr_d;
  logic       ovr_q, ovr_d;
  logic [7:0] errcnt_q, errcnt_d;
  logic [7:0] frmcnt_q, frmcnt_d;

  logic       frame_done;
  logic       frame_err;
  logic       ovr_set;
  logic       parity_now;

  // Parity of the frame as it would be if the current bit is P.
  assign parity_now = (^shreg_q) ^ bus.sin ^ ODD_BIT;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    shreg_d    = shreg_q;
    dout_d     = dout_q;
    dvalid_d   = dvalid_q;
    pec_d      = pec_q;
    toerr_d    = 1'b0;
    ovr_d      = ovr_q;
    errcnt_d   = errcnt_q;
    frmcnt_d   = frmcnt_q;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    ovr_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.svalid) begin
          shreg_d = {3'b000, bus.sin};
          idx_d   = 3'd1;
          timer_d = 8'd0;
          state_d = S_RX;
        end
      end

      S_RX: begin
        if (bus.svalid) begin
          timer_d = 8'd0;
          if (idx_q == IDX_P) begin
            dout_d     = shreg_q;
            pec_d      = parity_now;
            dvalid_d   = 1'b1;
            frame_done = 1'b1;
            frame_err  = parity_now;
            idx_d      = 3'd0;
            state_d    = S_HOLD;
          end else begin
            shreg_d = {shreg_q[2:0], bus.sin};
            idx_d   = idx_q + 3'd1;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Stalled frame: drop the partial bits without touching the counters.
          state_d = S_IDLE;
          idx_d   = 3'd0;
          timer_d = 8'd0;
          shreg_d = 4'd0;
          toerr_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_HOLD: begin
        if (bus.dready) begin
          dvalid_d = 1'b0;
          if (bus.svalid) begin
            shreg_d = {3'b000, bus.sin};
            idx_d   = 3'd1;
            timer_d = 8'd0;
            state_d = S_RX;
          end else begin
            state_d = S_IDLE;
          end
        end else if (bus.svalid) begin
          ovr_set = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear has priority over any increment or overrun set in the same cycle.
    if (clr_i) begin
      errcnt_d = 8'd0;
      frmcnt_d = 8'd0;
      ovr_d    = 1'b0;
    end else begin
      if (frame_done) frmcnt_d = frmcnt_q + 8'd1;
      if (frame_err && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
      if (ovr_set) ovr_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      timer_q  <= 8'd0;
      shreg_q  <= 4'd0;
      dout_q   <= 4'd0;
      dvalid_q <= 1'b0;
      pec_q    <= 1'b0;
      toerr_q  <= 1'b0;
      ovr_q    <= 1'b0;
      errcnt_q <= 8'd0;
      frmcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      pec_q    <= pec_d;
      toerr_q  <= toerr_d;
      ovr_q    <= ovr_d;
      errcnt_q <= errcnt_d;
      frmcnt_q <= frmcnt_d;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.pec    = pec_q;
  assign toerr_o    = toerr_q;
  assign ovr_o      = ovr_q;
  assign busy_o     = (state_q == S_RX) || (state_q == S_HOLD);
  assign errcnt_o   = errcnt_q;
  assign frmcnt_o   = frmcnt_q;

endmodule

// File: tb/tb_parity_check_ctrl.sv
// Directed bench for parity_check_ctrl (even parity, TIMEOUT=15).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_parity_check_ctrl;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       toerr;
  logic       ovr;
  logic       busy;
  logic [7:0] errcnt;
  logic [7:0] frmcnt;
  int         checks;
  int         errors;

  parity_check_ctrl_if bus ();

  parity_check_ctrl #(
    .ODD_PARITY (0),
    .TIMEOUT    (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .clr_i    (clr),
    .toerr_o  (toerr),
    .ovr_o    (ovr),
    .busy_o   (busy),
    .errcnt_o (errcnt),
    .frmcnt_o (frmcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.svalid = 1'b1;
    bus.sin    = b;
    tick();
    bus.svalid = 1'b0;
    bus.sin    = 1'b0;
  endtask

  // bits = {A,B,C,D,P}, sent A first.
  task automatic send_frame(input logic [4:0] bits);
    for (int i = 4; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.dout, bus.dvalid, bus.pec, toerr, ovr, busy} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000000",
               {bus.dout, bus.dvalid, bus.pec, toerr, ovr, busy});
    end
    checks++;
    if ({errcnt, frmcnt} !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got %h exp 0000", {errcnt, frmcnt});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_good_frame();
    bus.dready = 1'b1;
    pulse_clr();
    send_frame(5'b10111);
    checks++;
    if ({bus.dvalid, bus.dout, bus.pec} !== 6'b1_1011_0) begin
      errors++;
      $display("FAIL good_frame got %b exp 110110", {bus.dvalid, bus.dout, bus.pec});
    end
    checks++;
    if ({frmcnt, errcnt} !== {8'd1, 8'd0}) begin
      errors++;
      $display("FAIL good_counts got %h exp 0100", {frmcnt, errcnt});
    end
    tick();
    checks++;
    if ({bus.dvalid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL good_accept got %b exp 00", {bus.dvalid, busy});
    end
  endtask

  task automatic test_parity_error();
    send_frame(5'b10110);
    checks++;
    if ({bus.dvalid, bus.dout, bus.pec} !== 6'b1_1011_1) begin
      errors++;
      $display("FAIL perr_frame got %b exp 110111", {bus.dvalid, bus.dout, bus.pec});
    end
    checks++;
    if ({frmcnt, errcnt} !== {8'd2, 8'd1}) begin
      errors++;
      $display("FAIL perr_counts got %h exp 0201", {frmcnt, errcnt});
    end
    tick();
  endtask

  task automatic test_saturation();
    pulse_clr();
    for (int n = 0; n < 300; n++) begin
      send_frame(5'b10110);
      tick();
    end
    checks++;
    if (errcnt !== 8'd255) begin
      errors++;
      $display("FAIL errcnt_saturate got %0d exp 255", errcnt);
    end
    checks++;
    if (frmcnt !== 8'd44) begin
      errors++;
      $display("FAIL frmcnt_wrap got %0d exp 44", frmcnt);
    end
  endtask

  task automatic test_overrun();
    pulse_clr();
    bus.dready = 1'b0;
    send_frame(5'b11000);
    send_bit(1'b1);
    checks++;
    if ({ovr, bus.dvalid, bus.dout, bus.pec} !== 7'b1_1_1100_0) begin
      errors++;
      $display("FAIL ovr_set got %b exp 1111000", {ovr, bus.dvalid, bus.dout, bus.pec});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({bus.dvalid, bus.dout} !== 5'b1_1100) begin
      errors++;
      $display("FAIL hold_stable got %b exp 11100", {bus.dvalid, bus.dout});
    end
    // Accept and first bit of the next frame in the same cycle.
    bus.dready = 1'b1;
    send_bit(1'b0);
    checks++;
    if ({bus.dvalid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept got %b exp 01", {bus.dvalid, busy});
    end
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if ({bus.dvalid, bus.dout, bus.pec, ovr, frmcnt} !== {1'b1, 4'b0111, 1'b0, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL b2b_frame got %b exp 1011101_00000010",
               {bus.dvalid, bus.dout, bus.pec, ovr, frmcnt});
    end
    tick();
    pulse_clr();
    checks++;
    if ({ovr, frmcnt, bus.dout} !== {1'b0, 8'd0, 4'b0111}) begin
      errors++;
      $display("FAIL clr_ovr got %b exp 0_00000000_0111", {ovr, frmcnt, bus.dout});
    end
  endtask

  task automatic test_timeout();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if ({toerr, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early got %b exp 01", {toerr, busy});
    end
    tick();
    checks++;
    if ({toerr, busy, frmcnt} !== {2'b10, 8'd0}) begin
      errors++;
      $display("FAIL timeout_pulse got %b exp 10_00000000", {toerr, busy, frmcnt});
    end
    tick();
    checks++;
    if (toerr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_one_cycle got %b exp 0", toerr);
    end
    send_frame(5'b00011);
    checks++;
    if ({bus.dvalid, bus.dout, bus.pec, frmcnt} !== {6'b1_0001_0, 8'd1}) begin
      errors++;
      $display("FAIL after_timeout got %b exp 100010_00000001",
               {bus.dvalid, bus.dout, bus.pec, frmcnt});
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.dout, bus.dvalid, busy, frmcnt} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {bus.dout, bus.dvalid, busy, frmcnt});
    end
    #2 rst = 1'b0;
    send_bit(1'b1);
    checks++;
    if ({bus.dvalid, busy, frmcnt} !== {2'b01, 8'd0}) begin
      errors++;
      $display("FAIL post_reset_bitA got %b exp 01_00000000", {bus.dvalid, busy, frmcnt});
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if ({bus.dvalid, bus.dout, bus.pec, frmcnt} !== {6'b1_1100_0, 8'd1}) begin
      errors++;
      $display("FAIL post_reset_frame got %b exp 111000_00000001",
               {bus.dvalid, bus.dout, bus.pec, frmcnt});
    end
    tick();
  endtask

  task automatic test_clr_collision();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    clr = 1'b1;
    send_bit(1'b0);
    clr = 1'b0;
    checks++;
    if ({errcnt, frmcnt} !== 16'd0) begin
      errors++;
      $display("FAIL clr_wins got %h exp 0000", {errcnt, frmcnt});
    end
    checks++;
    if ({bus.dvalid, bus.dout, bus.pec} !== 6'b1_1011_1) begin
      errors++;
      $display("FAIL clr_frame got %b exp 110111", {bus.dvalid, bus.dout, bus.pec});
    end
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clr        = 1'b0;
    bus.sin    = 1'b0;
    bus.svalid = 1'b0;
    bus.dready = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_saturation();
    test_overrun();
    test_timeout();
    test_reset_mid_frame();
    test_clr_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
